// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - button synchronizer, press/release debounce and one-hot play detector
module detector_jogada #(
   parameter int DEBOUNCE = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] botoes,
   input  logic       habilita,
   output logic [8:0] jogada,
   output logic [3:0] jogada_idx,
   output logic       tem_jogada,
   output logic       jogada_invalida,
   output logic [3:0] db_estado
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ESTAVEL = 2'd1,
      EMITE   = 2'd2,
      SOLTA   = 2'd3
   } estado_t;

   localparam logic [15:0] CNT_FIM = 16'(DEBOUNCE - 1);

   estado_t     estado, estado_prox;
   logic [8:0]  s1, s2;
   logic [8:0]  padrao, padrao_prox;
   logic [15:0] cnt, cnt_prox;
   logic        carrega;
   logic        um_quente;

   function automatic logic [3:0] idx_de(input logic [8:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (v[i]) r = 4'(i + 1);
      end
      return r;
   endfunction

   assign um_quente = (padrao != 9'd0) && ((padrao & (padrao - 9'd1)) == 9'd0);

   always_comb begin
      estado_prox = estado;
      padrao_prox = padrao;
      cnt_prox    = cnt;
      carrega     = 1'b0;
      case (estado)
         OCIOSO: begin
            if (habilita && (s2 != 9'd0)) begin
               estado_prox = ESTAVEL;
               padrao_prox = s2;
               cnt_prox    = 16'd0;
            end
         end
         ESTAVEL: begin
            if (!habilita || (s2 == 9'd0)) begin
               estado_prox = OCIOSO;
            end else if (s2 != padrao) begin
               padrao_prox = s2;
               cnt_prox    = 16'd0;
            end else if (cnt == CNT_FIM) begin
               // play registers load on entry so they are valid alongside the strobe
               estado_prox = EMITE;
               carrega     = um_quente;
            end else begin
               cnt_prox = cnt + 16'd1;
            end
         end
         EMITE: begin
            estado_prox = SOLTA;
            cnt_prox    = 16'd0;
         end
         SOLTA: begin
            if (s2 != 9'd0) begin
               cnt_prox = 16'd0;
            end else if (cnt == CNT_FIM) begin
               estado_prox = OCIOSO;
            end else begin
               cnt_prox = cnt + 16'd1;
            end
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado     <= OCIOSO;
         s1         <= 9'd0;
         s2         <= 9'd0;
         padrao     <= 9'd0;
         cnt        <= 16'd0;
         jogada     <= 9'd0;
         jogada_idx <= 4'd0;
      end else begin
         estado <= estado_prox;
         s1     <= botoes;
         s2     <= s1;
         padrao <= padrao_prox;
         cnt    <= cnt_prox;
         if (carrega) begin
            jogada     <= padrao;
            jogada_idx <= idx_de(padrao);
         end
      end
   end

   assign tem_jogada      = (estado == EMITE) && um_quente;
   assign jogada_invalida = (estado == EMITE) && !um_quente;
   assign db_estado       = {2'b00, estado};

endmodule
